stim_select_datapath: RTL and testbench

Combined select datapath for the sine-stimulus driver: routes per-channel electrode-select switches to the 4-bit address bus, picks the 8-bit word for the active channel (or the reset word), and serializes one bit of that word onto the serial data line. It sits between the driver's sequencing FSM, which supplies the select indices, and the stimulator chip pins. All three selections are combinational. The two pin-facing outputs are registered on `clk_in`.

---
 rtl/stim_select_datapath.sv | 71 +++++++
 tb/tb_stim_select_datapath.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/stim_select_datapath.sv
// Select datapath for the sine-stimulus driver: address-switch routing, word
// selection and single-bit serialization toward the stimulator chip pins.
module stim_select_datapath #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk_in,
    input  logic              bt_res,
    input  logic              sw_cha0_sel3,
    input  logic              sw_cha0_sel2,
    input  logic              sw_cha0_sel1,
    input  logic              sw_cha0_sel0,
    input  logic              sw_cha1_sel3,
    input  logic              sw_cha1_sel2,
    input  logic              sw_cha1_sel1,
    input  logic              sw_cha1_sel0,
    input  logic [3:0]        adr_select,
    input  logic [DATA_W-1:0] reset_val,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [3:0]        cha_select,
    input  logic [IDX_W-1:0]  din_select,
    output logic [DATA_W-1:0] din_data,
    output logic              sel3,
    output logic              sel2,
    output logic              sel1,
    output logic              sel0,
    output logic              serial_din
);

    logic [3:0] adr_next;
    logic [3:0] sel_q;
    logic       serial_q;

    always_comb begin
        adr_next = '0;
        case (adr_select)
            4'd0:    adr_next = {sw_cha0_sel3, sw_cha0_sel2, sw_cha0_sel1, sw_cha0_sel0};
            4'd1:    adr_next = {sw_cha1_sel3, sw_cha1_sel2, sw_cha1_sel1, sw_cha1_sel0};
            default: adr_next = '0;
        endcase
    end

    always_comb begin
        din_data = '0;
        case (cha_select)
            4'd0:    din_data = reset_val;
            4'd1:    din_data = data0;
            4'd2:    din_data = data1;
            default: din_data = '0;
        endcase
    end

    // Pin-facing outputs are registered so the chip never sees mux glitches.
    always_ff @(posedge clk_in or negedge bt_res) begin
        if (!bt_res) begin
            sel_q    <= '0;
            serial_q <= 1'b0;
        end else begin
            sel_q    <= adr_next;
            serial_q <= din_data[din_select];
        end
    end

    assign sel3       = sel_q[3];
    assign sel2       = sel_q[2];
    assign sel1       = sel_q[1];
    assign sel0       = sel_q[0];
    assign serial_din = serial_q;

endmodule

// File: tb/tb_stim_select_datapath.sv
// Scoreboard bench for stim_select_datapath: stimulus pushes expected pin
// values, a monitor pops and compares them one cycle later.
module tb_stim_select_datapath;

    logic       clk_in = 1'b0;
    logic       bt_res;
    logic [3:0] sw0, sw1;
    logic [3:0] adr_select;
    logic [7:0] reset_val, data0, data1;
    logic [3:0] cha_select;
    logic [2:0] din_select;
    logic [7:0] din_data;
    logic       sel3, sel2, sel1, sel0, serial_din;

    typedef struct {
        logic [3:0] sel;
        logic       sd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_in = ~clk_in;

    stim_select_datapath #(.DATA_W(8), .IDX_W(3)) dut (
        .clk_in       (clk_in),
        .bt_res       (bt_res),
        .sw_cha0_sel3 (sw0[3]),
        .sw_cha0_sel2 (sw0[2]),
        .sw_cha0_sel1 (sw0[1]),
        .sw_cha0_sel0 (sw0[0]),
        .sw_cha1_sel3 (sw1[3]),
        .sw_cha1_sel2 (sw1[2]),
        .sw_cha1_sel1 (sw1[1]),
        .sw_cha1_sel0 (sw1[0]),
        .adr_select   (adr_select),
        .reset_val    (reset_val),
        .data0        (data0),
        .data1        (data1),
        .cha_select   (cha_select),
        .din_select   (din_select),
        .din_data     (din_data),
        .sel3         (sel3),
        .sel2         (sel2),
        .sel1         (sel1),
        .sel0         (sel0),
        .serial_din   (serial_din)
    );

    // Reference model: table lookups straight from the selection rules.
    function automatic logic [7:0] model_word(int cha, logic [7:0] rv, logic [7:0] d0, logic [7:0] d1);
        logic [7:0] words [3];
        words = '{rv, d0, d1};
        return (cha < 3) ? words[cha] : 8'h00;
    endfunction

    function automatic logic [3:0] model_adr(int adr, logic [3:0] s0, logic [3:0] s1);
        if (adr == 0) return s0;
        if (adr == 1) return s1;
        return 4'b0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs between edges, check the combinational word
    // and queue the pin values expected after the next rising edge.
    task automatic drive(input logic [3:0] a, input logic [3:0] c, input logic [2:0] d,
                         input logic [3:0] s0, input logic [3:0] s1,
                         input logic [7:0] rv, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] w;
        exp_t e;
        @(negedge clk_in);
        adr_select = a; cha_select = c; din_select = d;
        sw0 = s0; sw1 = s1; reset_val = rv; data0 = d0; data1 = d1;
        #1;
        w = model_word(int'(c), rv, d0, d1);
        check("din_data", {24'd0, din_data}, {24'd0, w});
        e.sel = model_adr(int'(a), s0, s1);
        e.sd  = (w >> d) & 8'h01;
        q.push_back(e);
    endtask

    // Async reset pulse between edges; the pending queue entry stays valid
    // because inputs are unchanged and the next edge reloads them.
    task automatic reset_pulse();
        #1 bt_res = 1'b0;
        #1;
        check("rst_sel", {28'd0, sel3, sel2, sel1, sel0}, 32'd0);
        check("rst_serial", {31'd0, serial_din}, 32'd0);
        bt_res = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sel_pins", {28'd0, sel3, sel2, sel1, sel0}, {28'd0, e.sel});
                check("serial_din", {31'd0, serial_din}, {31'd0, e.sd});
            end
        end
    end

    initial begin : stim
        bt_res = 1'b0;
        sw0 = '1; sw1 = '1; adr_select = '1; reset_val = '1; data0 = '1; data1 = '1;
        cha_select = '1; din_select = '1;
        #2;
        check("rst0_sel", {28'd0, sel3, sel2, sel1, sel0}, 32'd0);
        check("rst0_serial", {31'd0, serial_din}, 32'd0);
        cha_select = 4'd0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_din_data", {24'd0, din_data}, 32'h0000_00FF);
        check("rst_hold_sel", {28'd0, sel3, sel2, sel1, sel0}, 32'd0);
        @(negedge clk_in);
        bt_res = 1'b1;

        // Address routing
        drive(4'd0, 4'd0, 3'd0, 4'b1010, 4'b0101, 8'hFF, 8'hFF, 8'hFE);
        drive(4'd1, 4'd0, 3'd0, 4'b1010, 4'b0101, 8'hFF, 8'hFF, 8'hFE);
        drive(4'd7, 4'd0, 3'd0, 4'b1010, 4'b0101, 8'hFF, 8'hFF, 8'hFE);
        // Word routing
        drive(4'd0, 4'd0, 3'd7, 4'b1010, 4'b0101, 8'hFF, 8'hFF, 8'hFE);
        drive(4'd0, 4'd1, 3'd7, 4'b1010, 4'b0101, 8'hFF, 8'hFF, 8'hFE);
        drive(4'd0, 4'd2, 3'd7, 4'b1010, 4'b0101, 8'hFF, 8'hFF, 8'hFE);
        drive(4'd0, 4'd5, 3'd7, 4'b1010, 4'b0101, 8'hFF, 8'hFF, 8'hFE);
        // Serialization with a reset pulse mid-word
        for (int i = 0; i < 8; i++) begin
            drive(4'd1, 4'd2, 3'(i), 4'b1010, 4'b0101, 8'hFF, 8'hFF, 8'hFE);
            if (i == 4) reset_pulse();
        end
        // Simultaneous select change
        drive(4'd0, 4'd1, 3'd0, 4'b0011, 4'b1100, 8'h00, 8'h5A, 8'hA5);
        drive(4'd1, 4'd2, 3'd5, 4'b0011, 4'b1100, 8'h00, 8'h5A, 8'hA5);
        drive(4'd15, 4'd15, 3'd1, 4'b0011, 4'b1100, 8'h00, 8'h5A, 8'hA5);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] a, c;
            a = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            drive(a, c, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 19) == 0) reset_pulse();
        end

        repeat (2) @(posedge clk_in);
        #2;
        check("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
